// File: rtl/mmio_data_memory.sv
// Hack-style data memory: RAM, screen framebuffer with a display read port,
// and a keyboard FIFO with status/overflow, all in one CPU address space.
module mmio_data_memory #(
  parameter int WIDTH        = 16,
  parameter int ADDR_W       = 15,
  parameter int RAM_WORDS    = 16384,
  parameter int SCREEN_WORDS = 8192,
  parameter int KB_DEPTH     = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            load,
  input  logic [ADDR_W-1:0]               adr,
  input  logic [WIDTH-1:0]                d_in,
  output logic [WIDTH-1:0]                d_out,
  input  logic [$clog2(SCREEN_WORDS)-1:0] scr_adr,
  output logic [WIDTH-1:0]                scr_data,
  input  logic                            kb_valid,
  input  logic [WIDTH-1:0]                kb_code,
  output logic                            kb_ready,
  output logic                            kb_pending
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int SCR_AW = $clog2(SCREEN_WORDS);
  localparam int PTR_W  = $clog2(KB_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [ADDR_W-1:0] SCR_BASE   = ADDR_W'(RAM_WORDS);
  localparam logic [ADDR_W-1:0] KBD_DATA_A = ADDR_W'(RAM_WORDS + SCREEN_WORDS);
  localparam logic [ADDR_W-1:0] KBD_STAT_A = ADDR_W'(RAM_WORDS + SCREEN_WORDS + 1);
  localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(KB_DEPTH);

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_RAM  = 2'd1;
  localparam logic [1:0] SEL_SCR  = 2'd2;
  localparam logic [1:0] SEL_KBD  = 2'd3;

  logic [WIDTH-1:0] ram_mem [RAM_WORDS];
  logic [WIDTH-1:0] scr_mem [SCREEN_WORDS];
  logic [WIDTH-1:0] kb_mem  [KB_DEPTH];

  logic [RAM_AW-1:0] ram_idx;
  logic [SCR_AW-1:0] scr_idx;
  logic              is_ram, is_scr, is_kdat, is_kstat;

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              full, pop, push_ok, ovf_set, ovf_clr;

  logic [1:0]        rd_sel;
  logic [WIDTH-1:0]  kbd_next;

  logic [1:0]        sel_p1;
  logic [WIDTH-1:0]  ram_rd_p1, scr_rd_p1, kbd_rd_p1, disp_rd_p1;
  logic              disp_vld_p1;

  function automatic logic [WIDTH-1:0] pack_stat(input logic ovf,
                                                 input logic [CNT_W-1:0] cnt);
    logic [WIDTH-1:0] w;
    w            = '0;
    w[WIDTH-1]   = ovf;
    w[CNT_W-1:0] = cnt;
    return w;
  endfunction

  always_comb begin
    ram_idx  = RAM_AW'(adr);
    scr_idx  = SCR_AW'(adr - SCR_BASE);
    is_ram   = (adr < SCR_BASE);
    is_scr   = (adr >= SCR_BASE) && (adr < KBD_DATA_A);
    is_kdat  = (adr == KBD_DATA_A);
    is_kstat = (adr == KBD_STAT_A);
  end

  // A full FIFO still accepts a push when the same edge pops the head
  always_comb begin
    full     = (count == FULL_CNT);
    pop      = !load && is_kdat && (count != '0);
    push_ok  = kb_valid && (!full || pop);
    ovf_set  = kb_valid && full && !pop;
    ovf_clr  = load && is_kstat && d_in[WIDTH-1];
  end

  always_comb begin
    rd_sel   = SEL_NONE;
    kbd_next = '0;
    if (!load) begin
      if (is_ram)                   rd_sel = SEL_RAM;
      else if (is_scr)              rd_sel = SEL_SCR;
      else if (is_kdat || is_kstat) rd_sel = SEL_KBD;
    end
    if (is_kdat)       kbd_next = pop ? kb_mem[rd_ptr] : '0;
    else if (is_kstat) kbd_next = pack_stat(overflow, count);
  end

  // ---- stage p1: array writes and registered reads (old data on collision)
  always_ff @(posedge clk) begin
    if (reset && load && is_ram) ram_mem[ram_idx] <= d_in;
    if (reset && load && is_scr) scr_mem[scr_idx] <= d_in;
    if (reset && push_ok)        kb_mem[wr_ptr]   <= kb_code;
    ram_rd_p1  <= ram_mem[ram_idx];
    scr_rd_p1  <= scr_mem[scr_idx];
    disp_rd_p1 <= scr_mem[scr_adr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      sel_p1      <= SEL_NONE;
      kbd_rd_p1   <= '0;
      disp_vld_p1 <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop)      count <= count + CNT_W'(1);
      else if (!push_ok && pop) count <= count - CNT_W'(1);
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      sel_p1      <= rd_sel;
      kbd_rd_p1   <= kbd_next;
      disp_vld_p1 <= 1'b1;
    end
  end

  // ---- output: select among p1 read registers; reset forces zero
  always_comb begin
    d_out = '0;
    case (sel_p1)
      SEL_RAM: d_out = ram_rd_p1;
      SEL_SCR: d_out = scr_rd_p1;
      SEL_KBD: d_out = kbd_rd_p1;
      default: d_out = '0;
    endcase
  end

  assign scr_data   = disp_vld_p1 ? disp_rd_p1 : '0;
  assign kb_ready   = (count != FULL_CNT);
  assign kb_pending = (count != '0);

endmodule

// File: tb/tb_mmio_data_memory.sv
// Directed bench for mmio_data_memory: RAM/screen access, keyboard FIFO,
// overflow handling and asynchronous reset.
module tb_mmio_data_memory;

  localparam logic [14:0] K    = 15'h6000;
  localparam logic [14:0] IDLE = 15'd5;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [14:0] adr;
  logic [15:0] d_in;
  logic [15:0] d_out;
  logic [12:0] scr_adr;
  logic [15:0] scr_data;
  logic        kb_valid;
  logic [15:0] kb_code;
  logic        kb_ready;
  logic        kb_pending;

  int tests = 0;
  int fails = 0;

  mmio_data_memory dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .adr        (adr),
    .d_in       (d_in),
    .d_out      (d_out),
    .scr_adr    (scr_adr),
    .scr_data   (scr_data),
    .kb_valid   (kb_valid),
    .kb_code    (kb_code),
    .kb_ready   (kb_ready),
    .kb_pending (kb_pending)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [14:0] a, input logic [15:0] d);
    load = 1'b1; adr = a; d_in = d;
    cyc();
    load = 1'b0; adr = IDLE;
  endtask

  task automatic rd(input logic [14:0] a, input string tag, input logic [15:0] exp);
    load = 1'b0; adr = a;
    cyc();
    chk(tag, d_out, exp);
    adr = IDLE;
  endtask

  task automatic push(input logic [15:0] c);
    kb_valid = 1'b1; kb_code = c;
    cyc();
    kb_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; adr = IDLE; d_in = '0;
    scr_adr = '0; kb_valid = 1'b0; kb_code = '0;
    #3;
    chk("rst_d_out", d_out, 16'h0000);
    chk("rst_scr_data", scr_data, 16'h0000);
    chk("rst_kb_ready", {15'd0, kb_ready}, 16'h0001);
    chk("rst_kb_pending", {15'd0, kb_pending}, 16'h0000);
    cyc(); cyc();
    reset = 1'b1;
    cyc();

    // RAM write/read, write cycle yields 0, unmapped address reads 0
    wr(15'd5, 16'h1234);
    chk("wr_cycle_d_out", d_out, 16'h0000);
    rd(15'd5, "ram_rd5", 16'h1234);
    rd(15'h7FFF, "unmapped_rd", 16'h0000);

    // Screen: display port sees old word on same-cycle write
    wr(15'h4003, 16'h00AA);
    scr_adr = 13'd3;
    load = 1'b1; adr = 15'h4003; d_in = 16'hFFFF;
    cyc();
    chk("scr_old", scr_data, 16'h00AA);
    load = 1'b0; adr = IDLE;
    cyc();
    chk("scr_new", scr_data, 16'hFFFF);
    rd(15'h4003, "scr_cpu_rd", 16'hFFFF);

    // Keyboard FIFO order and empty read
    push(16'h0041); push(16'h0042); push(16'h0043);
    chk("kb_pending3", {15'd0, kb_pending}, 16'h0001);
    rd(K + 15'd1, "stat_cnt3", 16'h0003);
    rd(K, "pop_41", 16'h0041);
    rd(K, "pop_42", 16'h0042);
    rd(K, "pop_43", 16'h0043);
    rd(K + 15'd1, "stat_cnt0", 16'h0000);
    rd(K, "pop_empty", 16'h0000);
    rd(K + 15'd1, "stat_still0", 16'h0000);
    chk("kb_pending0", {15'd0, kb_pending}, 16'h0000);

    // Overflow: 9 pushes into 8 entries
    for (int i = 1; i <= 9; i++) begin
      push(16'(16'h0100 + i));
      if (i == 7) chk("kb_ready_7", {15'd0, kb_ready}, 16'h0001);
      if (i == 8) chk("kb_ready_8", {15'd0, kb_ready}, 16'h0000);
    end
    rd(K + 15'd1, "stat_ovf", 16'h8008);
    wr(K + 15'd1, 16'h8000);
    rd(K + 15'd1, "stat_ovf_clr", 16'h0008);

    // Full FIFO: push and pop on the same edge
    kb_valid = 1'b1; kb_code = 16'h0055; load = 1'b0; adr = K;
    cyc();
    chk("pushpop_head", d_out, 16'h0101);
    kb_valid = 1'b0; adr = IDLE;
    rd(K + 15'd1, "pushpop_stat", 16'h0008);
    for (int i = 2; i <= 8; i++) rd(K, "drain", 16'(16'h0100 + i));
    rd(K, "drain_last55", 16'h0055);
    rd(K + 15'd1, "drain_stat", 16'h0000);

    // Asynchronous reset mid-stream
    push(16'h0071); push(16'h0072); push(16'h0073);
    rd(15'd5, "pre_rst_rd", 16'h1234);
    adr = K;
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_d_out", d_out, 16'h0000);
    chk("midrst_pending", {15'd0, kb_pending}, 16'h0000);
    chk("midrst_ready", {15'd0, kb_ready}, 16'h0001);
    cyc();
    reset = 1'b1; adr = IDLE;
    rd(K + 15'd1, "post_rst_stat", 16'h0000);
    rd(K, "post_rst_pop", 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mmio_data_memory.md
# mmio_data_memory

Parametrised memory-mapped data memory for the Hack-style CPU. It provides general RAM, a screen framebuffer with a dedicated display read port, and a buffered keyboard input channel with FIFO, status and overflow reporting, all in one CPU-visible address space. It sits between the CPU data port and the screen/keyboard peripherals. Unlike the previous single-word keyboard register, it queues key codes so none are lost between CPU polls.

## Interface
Parameters:
- WIDTH, 16, data word width (≥ 9)
- ADDR_W, 15, CPU address width
- RAM_WORDS, 16384, general RAM words at base 0
- SCREEN_WORDS, 8192, framebuffer words at base RAM_WORDS
- KB_DEPTH, 8, keyboard FIFO entries (power of two, 2..128)

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- load  input  1  CPU write enable
- adr  input  ADDR_W  CPU address
- d_in  input  WIDTH  CPU write data
- d_out  output  WIDTH  CPU read data, registered
- scr_adr  input  $clog2(SCREEN_WORDS)  display read address
- scr_data  output  WIDTH  display read data, registered
- kb_valid  input  1  key code offered
- kb_code  input  WIDTH  key code
- kb_ready  output  1  FIFO not full
- kb_pending  output  1  FIFO not empty

## Operation
Address map (K = RAM_WORDS + SCREEN_WORDS):
- [0, RAM_WORDS): RAM, read/write.
- [RAM_WORDS, K): screen, read/write.
- K: KBD_DATA. A read returns the FIFO head and pops it. Reading while empty returns 0 and does not pop. Writes are ignored.
- K+1: KBD_STAT. A read returns bit WIDTH-1 = overflow, bits [7:0] = count, other bits 0, with no side effect. A write with d_in[WIDTH-1]=1 clears overflow.
- All other addresses: reads return 0 and writes are ignored.

Access rules:
- "Read" means any cycle with load=0. A pop occurs only when load=0 and adr=K at the rising edge.
- Keyboard push: kb_valid=1 at a rising edge.
  - FIFO not full: kb_code is enqueued.
  - FIFO full with no pop in the same cycle: kb_code is dropped and overflow is set (sticky).
  - FIFO full with a pop in the same cycle: the push is accepted, count is unchanged and overflow is not set.
- Overflow set and clear in the same cycle: set wins.
- FIFO pointers wrap modulo KB_DEPTH. count ranges 0..KB_DEPTH and is held in $clog2(KB_DEPTH)+1 bits.
- kb_ready = (count != KB_DEPTH) and kb_pending = (count != 0). Both are combinational from registered count.
- RAM and screen are write-first-free arrays (read-old-data), with no reset of contents.

## Timing
- On reset assertion (immediate, asynchronous): d_out=0, scr_data=0, count=0, FIFO pointers=0, overflow=0. As a result kb_ready=1 and kb_pending=0. RAM and screen contents are undefined and not cleared.
- Read latency is 1 cycle. d_out in cycle n+1 reflects adr in cycle n. In a load=1 cycle, d_out in cycle n+1 is 0.
- Write occurs at the edge where load=1; the new data is readable from the next cycle's address.
- Same-address CPU write and display read in one cycle: scr_data returns the old word.
- KBD_DATA read: d_out in cycle n+1 holds the head as of cycle n, and count decrements at the same edge.
- Push and pop in the same cycle on a non-empty FIFO: count is unchanged.
- Push into an empty FIFO: visible to a KBD_DATA read issued in the next cycle.
- Reset mid-operation: any in-flight pop or write is abandoned and FIFO contents are discarded.

## Test plan
- Reset, then write 0x1234 to RAM address 5 and read it back. Required: d_out = 0x1234 one cycle after the read. Reading address 0x7FFF returns 0.
- Write 0xFFFF to screen word 3 (adr = RAM_WORDS+3) with scr_adr=3 in the same cycle. Required: scr_data = old value. In the next cycle scr_data = 0xFFFF.
- Push 0x41, 0x42, 0x43, then read KBD_DATA three times. Required: d_out sequence 0x41, 0x42, 0x43, and KBD_STAT count goes 3→0. A fourth read returns 0 and count stays 0.
- Push 9 codes with KB_DEPTH=8 and no pops. Required: kb_ready=0 after the 8th push, the 9th code is dropped, and KBD_STAT = 0x8008. Write 0x8000 to K+1: KBD_STAT = 0x0008.
- With the FIFO full, push 0x55 while popping in the same cycle. Required: head is returned, count stays 8, overflow stays 0, and 0x55 is the last entry popped.
- Assert reset mid-stream with 3 entries queued. Required: d_out=0, kb_pending=0 and count=0 immediately. After reset, a KBD_DATA read returns 0.
